// File: rtl/cavlc_pkg.sv
// Shared CAVLC encoder types: FSM state encoding, block size and the run_before code table.
// Latency: purely declarative; run_before_code is combinational.
// Backpressure: none.
package cavlc_pkg;

  localparam int MAX_NUM_COEFF = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TOTAL_ZERO = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  // Returns {bits[10:0], len[3:0]} with the codeword left-justified in bits.
  // For zeros_left > 6 a single column serves every value: runs 0..6 are
  // 3-bit codes (7-run), longer runs are a unary-style 1 preceded by zeros.
  function automatic logic [14:0] run_before_code(input logic [3:0] zeros_left,
                                                  input logic [3:0] run);
    logic [10:0] v;
    logic [3:0]  l;
    logic [10:0] bits;
    v = '0;
    l = '0;
    if (zeros_left > 4'd6) begin
      if (run < 4'd7) begin
        v = {7'd0, 4'd7 - run};
        l = 4'd3;
      end else begin
        v = 11'd1;
        l = run - 4'd3;
      end
    end else begin
      case (zeros_left)
        4'd1: case (run)
          4'd0: {l, v} = {4'd1, 11'd1};
          4'd1: {l, v} = {4'd1, 11'd0};
          default: {l, v} = '0;
        endcase
        4'd2: case (run)
          4'd0: {l, v} = {4'd1, 11'd1};
          4'd1: {l, v} = {4'd2, 11'd1};
          4'd2: {l, v} = {4'd2, 11'd0};
          default: {l, v} = '0;
        endcase
        4'd3: case (run)
          4'd0: {l, v} = {4'd2, 11'd3};
          4'd1: {l, v} = {4'd2, 11'd2};
          4'd2: {l, v} = {4'd2, 11'd1};
          4'd3: {l, v} = {4'd2, 11'd0};
          default: {l, v} = '0;
        endcase
        4'd4: case (run)
          4'd0: {l, v} = {4'd2, 11'd3};
          4'd1: {l, v} = {4'd2, 11'd2};
          4'd2: {l, v} = {4'd2, 11'd1};
          4'd3: {l, v} = {4'd3, 11'd1};
          4'd4: {l, v} = {4'd3, 11'd0};
          default: {l, v} = '0;
        endcase
        4'd5: case (run)
          4'd0: {l, v} = {4'd2, 11'd3};
          4'd1: {l, v} = {4'd2, 11'd2};
          4'd2: {l, v} = {4'd3, 11'd3};
          4'd3: {l, v} = {4'd3, 11'd2};
          4'd4: {l, v} = {4'd3, 11'd1};
          4'd5: {l, v} = {4'd3, 11'd0};
          default: {l, v} = '0;
        endcase
        4'd6: case (run)
          4'd0: {l, v} = {4'd2, 11'd3};
          4'd1: {l, v} = {4'd3, 11'd0};
          4'd2: {l, v} = {4'd3, 11'd1};
          4'd3: {l, v} = {4'd3, 11'd3};
          4'd4: {l, v} = {4'd3, 11'd2};
          4'd5: {l, v} = {4'd3, 11'd5};
          4'd6: {l, v} = {4'd3, 11'd4};
          default: {l, v} = '0;
        endcase
        default: {l, v} = '0;
      endcase
    end
    bits = v << (4'd11 - l);
    return {bits, l};
  endfunction

endpackage

// File: rtl/total_zero_enc_table.sv
// total_zeros codeword lookup for 4x4 blocks, mirroring the zero decoder's table.
// Latency: combinational. Backpressure: none.
// Ports: i_total_coeff (1..15), i_total_zeros -> o_code (9b, MSB-aligned, low bits 0), o_len (1..9).
module total_zero_enc_table (
  input  logic [4:0] i_total_coeff,
  input  logic [3:0] i_total_zeros,
  output logic [8:0] o_code,
  output logic [3:0] o_len
);

  // {len, right-justified value}; key is {TotalCoeff, TotalZeros}.
  logic [12:0] w_lv;

  always_comb begin
    w_lv = '0;
    case ({i_total_coeff, i_total_zeros})
      9'h010: w_lv = {4'd1, 9'd1}; 9'h011: w_lv = {4'd3, 9'd3}; 9'h012: w_lv = {4'd3, 9'd2}; 9'h013: w_lv = {4'd4, 9'd3};
      9'h014: w_lv = {4'd4, 9'd2}; 9'h015: w_lv = {4'd5, 9'd3}; 9'h016: w_lv = {4'd5, 9'd2}; 9'h017: w_lv = {4'd6, 9'd3};
      9'h018: w_lv = {4'd6, 9'd2}; 9'h019: w_lv = {4'd7, 9'd3}; 9'h01A: w_lv = {4'd7, 9'd2}; 9'h01B: w_lv = {4'd8, 9'd3};
      9'h01C: w_lv = {4'd8, 9'd2}; 9'h01D: w_lv = {4'd9, 9'd3}; 9'h01E: w_lv = {4'd9, 9'd2}; 9'h01F: w_lv = {4'd9, 9'd1};
      9'h020: w_lv = {4'd3, 9'd7}; 9'h021: w_lv = {4'd3, 9'd6}; 9'h022: w_lv = {4'd3, 9'd5}; 9'h023: w_lv = {4'd3, 9'd4};
      9'h024: w_lv = {4'd3, 9'd3}; 9'h025: w_lv = {4'd4, 9'd5}; 9'h026: w_lv = {4'd4, 9'd4}; 9'h027: w_lv = {4'd4, 9'd3};
      9'h028: w_lv = {4'd4, 9'd2}; 9'h029: w_lv = {4'd5, 9'd3}; 9'h02A: w_lv = {4'd5, 9'd2}; 9'h02B: w_lv = {4'd6, 9'd3};
      9'h02C: w_lv = {4'd6, 9'd2}; 9'h02D: w_lv = {4'd6, 9'd1}; 9'h02E: w_lv = {4'd6, 9'd0};
      9'h030: w_lv = {4'd4, 9'd5}; 9'h031: w_lv = {4'd3, 9'd7}; 9'h032: w_lv = {4'd3, 9'd6}; 9'h033: w_lv = {4'd3, 9'd5};
      9'h034: w_lv = {4'd4, 9'd4}; 9'h035: w_lv = {4'd4, 9'd3}; 9'h036: w_lv = {4'd3, 9'd4}; 9'h037: w_lv = {4'd3, 9'd3};
      9'h038: w_lv = {4'd4, 9'd2}; 9'h039: w_lv = {4'd5, 9'd3}; 9'h03A: w_lv = {4'd5, 9'd2}; 9'h03B: w_lv = {4'd6, 9'd1};
      9'h03C: w_lv = {4'd5, 9'd1}; 9'h03D: w_lv = {4'd6, 9'd0};
      9'h040: w_lv = {4'd5, 9'd3}; 9'h041: w_lv = {4'd3, 9'd7}; 9'h042: w_lv = {4'd4, 9'd5}; 9'h043: w_lv = {4'd4, 9'd4};
      9'h044: w_lv = {4'd3, 9'd6}; 9'h045: w_lv = {4'd3, 9'd5}; 9'h046: w_lv = {4'd3, 9'd4}; 9'h047: w_lv = {4'd4, 9'd3};
      9'h048: w_lv = {4'd3, 9'd3}; 9'h049: w_lv = {4'd4, 9'd2}; 9'h04A: w_lv = {4'd5, 9'd2}; 9'h04B: w_lv = {4'd5, 9'd1};
      9'h04C: w_lv = {4'd5, 9'd0};
      9'h050: w_lv = {4'd4, 9'd5}; 9'h051: w_lv = {4'd4, 9'd4}; 9'h052: w_lv = {4'd4, 9'd3}; 9'h053: w_lv = {4'd3, 9'd7};
      9'h054: w_lv = {4'd3, 9'd6}; 9'h055: w_lv = {4'd3, 9'd5}; 9'h056: w_lv = {4'd3, 9'd4}; 9'h057: w_lv = {4'd3, 9'd3};
      9'h058: w_lv = {4'd4, 9'd2}; 9'h059: w_lv = {4'd5, 9'd1}; 9'h05A: w_lv = {4'd4, 9'd1}; 9'h05B: w_lv = {4'd5, 9'd0};
      9'h060: w_lv = {4'd6, 9'd1}; 9'h061: w_lv = {4'd5, 9'd1}; 9'h062: w_lv = {4'd3, 9'd7}; 9'h063: w_lv = {4'd3, 9'd6};
      9'h064: w_lv = {4'd3, 9'd5}; 9'h065: w_lv = {4'd3, 9'd4}; 9'h066: w_lv = {4'd3, 9'd3}; 9'h067: w_lv = {4'd3, 9'd2};
      9'h068: w_lv = {4'd4, 9'd1}; 9'h069: w_lv = {4'd3, 9'd1}; 9'h06A: w_lv = {4'd6, 9'd0};
      9'h070: w_lv = {4'd6, 9'd1}; 9'h071: w_lv = {4'd5, 9'd1}; 9'h072: w_lv = {4'd3, 9'd5}; 9'h073: w_lv = {4'd3, 9'd4};
      9'h074: w_lv = {4'd3, 9'd3}; 9'h075: w_lv = {4'd2, 9'd3}; 9'h076: w_lv = {4'd3, 9'd2}; 9'h077: w_lv = {4'd4, 9'd1};
      9'h078: w_lv = {4'd3, 9'd1}; 9'h079: w_lv = {4'd6, 9'd0};
      9'h080: w_lv = {4'd6, 9'd1}; 9'h081: w_lv = {4'd4, 9'd1}; 9'h082: w_lv = {4'd5, 9'd1}; 9'h083: w_lv = {4'd3, 9'd3};
      9'h084: w_lv = {4'd2, 9'd3}; 9'h085: w_lv = {4'd2, 9'd2}; 9'h086: w_lv = {4'd3, 9'd2}; 9'h087: w_lv = {4'd3, 9'd1};
      9'h088: w_lv = {4'd6, 9'd0};
      9'h090: w_lv = {4'd6, 9'd1}; 9'h091: w_lv = {4'd6, 9'd0}; 9'h092: w_lv = {4'd4, 9'd1}; 9'h093: w_lv = {4'd2, 9'd3};
      9'h094: w_lv = {4'd2, 9'd2}; 9'h095: w_lv = {4'd3, 9'd1}; 9'h096: w_lv = {4'd2, 9'd1}; 9'h097: w_lv = {4'd5, 9'd1};
      9'h0A0: w_lv = {4'd5, 9'd1}; 9'h0A1: w_lv = {4'd5, 9'd0}; 9'h0A2: w_lv = {4'd3, 9'd1}; 9'h0A3: w_lv = {4'd2, 9'd3};
      9'h0A4: w_lv = {4'd2, 9'd2}; 9'h0A5: w_lv = {4'd2, 9'd1}; 9'h0A6: w_lv = {4'd4, 9'd1};
      9'h0B0: w_lv = {4'd4, 9'd0}; 9'h0B1: w_lv = {4'd4, 9'd1}; 9'h0B2: w_lv = {4'd3, 9'd1}; 9'h0B3: w_lv = {4'd3, 9'd2};
      9'h0B4: w_lv = {4'd1, 9'd1}; 9'h0B5: w_lv = {4'd3, 9'd3};
      9'h0C0: w_lv = {4'd4, 9'd0}; 9'h0C1: w_lv = {4'd4, 9'd1}; 9'h0C2: w_lv = {4'd2, 9'd1}; 9'h0C3: w_lv = {4'd1, 9'd1};
      9'h0C4: w_lv = {4'd3, 9'd1};
      9'h0D0: w_lv = {4'd3, 9'd0}; 9'h0D1: w_lv = {4'd3, 9'd1}; 9'h0D2: w_lv = {4'd1, 9'd1}; 9'h0D3: w_lv = {4'd2, 9'd1};
      9'h0E0: w_lv = {4'd2, 9'd0}; 9'h0E1: w_lv = {4'd2, 9'd1}; 9'h0E2: w_lv = {4'd1, 9'd1};
      9'h0F0: w_lv = {4'd1, 9'd0}; 9'h0F1: w_lv = {4'd1, 9'd1};
      default: w_lv = '0;
    endcase
  end

  assign o_len  = w_lv[12:9];
  assign o_code = w_lv[8:0] << (4'd9 - w_lv[12:9]);

endmodule

// File: rtl/zero_encode.sv
// CAVLC 4x4 zero-run encoder: emits total_zeros then run_before codewords for one mask.
// Latency: first codeword the cycle after Start; one codeword per cycle; Done one cycle after last transfer.
// Backpressure: codeword held stable while o_code_valid && !i_code_ready; Start only taken in IDLE.
// Ports: i_clk, i_reset (sync, active-high), i_start/i_coeff_mask in, o_ready, o_code_bits (MSB-aligned),
//        o_code_len, o_code_valid, i_code_ready, o_done (1-cycle pulse).
module zero_encode
  import cavlc_pkg::*;
#(
  parameter int CODE_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [15:0]       i_coeff_mask,
  output logic              o_ready,
  output logic [CODE_W-1:0] o_code_bits,
  output logic [4:0]        o_code_len,
  output logic              o_code_valid,
  input  logic              i_code_ready,
  output logic              o_done
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_mask;
  logic [4:0]  r_tc;
  logic [3:0]  r_zl;
  logic [3:0]  r_pos;
  logic [3:0]  r_cnt;

  logic [4:0]  w_tc;
  logic [3:0]  w_last;
  logic [3:0]  w_zl_init;
  logic [3:0]  w_next;
  logic [3:0]  w_run;
  logic [3:0]  w_zl_after;
  logic [14:0] w_rb;
  logic [8:0]  w_tz_code;
  logic [3:0]  w_tz_len;
  logic        w_start_acc;
  logic        w_xfer;

  // Popcount and highest set bit of the incoming mask.
  always_comb begin
    w_tc   = '0;
    w_last = '0;
    for (int i = 0; i < MAX_NUM_COEFF; i++) begin
      w_tc = w_tc + {4'd0, i_coeff_mask[i]};
      if (i_coeff_mask[i]) w_last = 4'(i);
    end
  end

  // Modulo-16 arithmetic is exact here: a full mask wraps to 0 as required.
  assign w_zl_init = (w_tc == 5'd0) ? 4'd0 : (w_last + 4'd1 - w_tc[3:0]);

  // Highest coefficient strictly below the current position.
  always_comb begin
    w_next = '0;
    for (int i = 0; i < MAX_NUM_COEFF; i++) begin
      if (r_mask[i] && (4'(i) < r_pos)) w_next = 4'(i);
    end
  end

  assign w_run       = r_pos - w_next - 4'd1;
  assign w_zl_after  = r_zl - w_run;
  assign w_rb        = run_before_code(r_zl, w_run);
  assign w_start_acc = i_start && (r_state == IDLE);
  assign w_xfer      = o_code_valid && i_code_ready;

  total_zero_enc_table u_tz_table (
    .i_total_coeff (r_tc),
    .i_total_zeros (r_zl),
    .o_code        (w_tz_code),
    .o_len         (w_tz_len)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_tc    <= '0;
      r_zl    <= '0;
      r_pos   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start_acc) begin
        r_mask <= i_coeff_mask;
        r_tc   <= w_tc;
        r_zl   <= w_zl_init;
        r_pos  <= w_last;
        r_cnt  <= '0;
      end else if ((r_state == RUN) && w_xfer) begin
        r_zl  <= w_zl_after;
        r_pos <= w_next;
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_ready      = 1'b0;
    o_code_valid = 1'b0;
    o_code_bits  = '0;
    o_code_len   = '0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          w_next_state = ((w_tc == 5'd0) || (w_tc == 5'd16)) ? DONE : TOTAL_ZERO;
        end
      end
      TOTAL_ZERO: begin
        o_code_valid                  = 1'b1;
        o_code_bits[CODE_W-1 -: 9]    = w_tz_code;
        o_code_len                    = {1'b0, w_tz_len};
        if (i_code_ready) begin
          w_next_state = ((r_zl == 4'd0) || (r_tc == 5'd1)) ? DONE : RUN;
        end
      end
      RUN: begin
        o_code_valid                  = 1'b1;
        o_code_bits[CODE_W-1 -: 11]   = w_rb[14:4];
        o_code_len                    = {1'b0, w_rb[3:0]};
        // The lowest coefficient never gets a run_before, hence TC-1 codes at most.
        if (i_code_ready &&
            ((w_zl_after == 4'd0) || (({1'b0, r_cnt} + 5'd1) == (r_tc - 5'd1)))) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: doc/zero_encode.md
# zero_encode

Encodes the zero-run side of one CAVLC 4x4 block, for 16-coefficient blocks only. It takes a nonzero-coefficient mask in scan order and emits the total_zeros codeword followed by the run_before codewords. It sits in the CAVLC encoder next to the coeff_token and level encoders, and is the inverse of the zero decoder. Codewords leave MSB-aligned through a valid/ready handshake to the bitstream packer.

## Interface
- CODE_W, 16: width of the CodeBits output. Must be at least 11, the longest run_before code.
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request to encode one block; accepted only while Ready=1
- CoeffMask  in  16  bit i = 1 when the coefficient at scan position i is nonzero; sampled on Start acceptance
- Ready  out  1  high in IDLE only
- CodeBits  out  CODE_W  codeword MSB-aligned at bit CODE_W-1; unused low bits are 0
- CodeLen  out  5  codeword length, 1..11
- CodeValid  out  1  CodeBits/CodeLen are valid
- CodeReady  in  1  downstream accepts; a transfer happens when CodeValid && CodeReady
- Done  out  1  one-cycle pulse when the block is finished

## Operation
- Start acceptance registers the following values:
  - Mask = CoeffMask.
  - TotalCoeff = popcount(CoeffMask), 5 bits.
  - Last = index of the highest set bit, 0 when the mask is zero.
  - ZerosLeft = Last+1-TotalCoeff, 4 bits, 0 when TotalCoeff=0.
  - Pos = Last.
  - CoeffCnt = 0.
- States and transitions:
  - IDLE -> TOTAL_ZERO on Start when TotalCoeff is 1..15.
  - IDLE -> DONE on Start when TotalCoeff is 0 or 16. No codeword is emitted in this case.
  - TOTAL_ZERO: present the total_zeros code for (TotalCoeff, ZerosLeft) from H.264 Table 9-7/9-8, 4x4 column. On transfer, go to DONE if ZerosLeft==0 or TotalCoeff==1; otherwise go to RUN.
  - RUN, steps:
    - Next = highest set Mask bit below Pos.
    - Run = Pos-Next-1.
    - Present the run_before code for (ZerosLeft, Run) from Table 9-10. ZerosLeft>6 uses the same column for every value.
    - On transfer: ZerosLeft -= Run, Pos = Next, CoeffCnt += 1.
    - Go to DONE when the new ZerosLeft==0 or CoeffCnt+1==TotalCoeff-1.
  - DONE: Done=1 for one cycle, then IDLE.
- No run_before is emitted for the lowest-frequency coefficient.
- Run never exceeds ZerosLeft for a legal mask. The table output for an out-of-range Run is don't-care and is never presented.
- Start is ignored while Ready=0.

## Timing
- Reset values: state IDLE, Ready=1, CodeValid=0, CodeBits=0, CodeLen=0, Done=0. All internal registers are 0.
- Start accepted in cycle N:
  - CodeValid=1 in cycle N+1, carrying the total_zeros code.
  - For TotalCoeff 0 or 16, Done=1 in N+1 instead.
- With CodeReady held high, one codeword transfers per cycle. Done follows the last transfer by one cycle. Ready returns the cycle after Done.
- While CodeValid=1 and CodeReady=0, CodeBits and CodeLen hold stable.
- CodeValid is never dropped without a transfer.
- Reset asserted mid-block returns the block to IDLE at the next edge. The partial codeword sequence is abandoned and no Done is produced.
- Start in the same cycle as the Done pulse is ignored, because Ready=0 in that cycle.

## Structure
- Shared package, cavlc_pkg, holds:
  - the state enum (IDLE, TOTAL_ZERO, RUN, DONE);
  - MAX_NUM_COEFF=16;
  - a function run_before_code(zerosLeft, run) returning {bits[10:0], len[3:0]}.
- One sub-module, total_zero_enc_table: combinational (TotalCoeff, TotalZeroes) -> 9-bit MSB-aligned code plus 4-bit length. It mirrors the decoder's table.
- Priority encoders for Last and Next are inline.

## Test plan
- Mask 16'h002D (positions 0,2,3,5; TC=4, tz=2). Required codewords, then Done:
  - '0101'/4
  - '01'/2
  - '1'/1
  - '0'/1
- Mask 16'h0001 -> one codeword '1'/1, then Done. No run_before.
- Mask 16'h8001 (TC=2, tz=14) -> '000000'/6, then '00000000001'/11.
- Mask 16'h8000 -> '000000001'/9.
- Mask 16'h0000 -> no CodeValid; Done in N+1.
- Mask 16'hFFFF -> no CodeValid; Done in N+1.
- Mask 16'h002D with CodeReady random 50%, and Reset pulsed after the second transfer of a repeat run:
  - sequence matches the first scenario, with outputs stable while stalled;
  - after Reset, outputs return to reset values, no Done, Ready=1.
